// File: rtl/rom_streamer.sv
// Address sequencer and 2-entry output buffer for a synchronous-read ROM.
// Walks len addresses from base, hides the 1-cycle read latency, and streams words with backpressure.
module rom_streamer #(
    parameter int n = 8,
    parameter int m = 512,
    localparam int a = $clog2(m)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [a-1:0] base,
    input  logic [a:0]   len,
    input  logic         abort,
    output logic [a-1:0] addr_o,
    input  logic [n-1:0] rom_d,
    output logic [n-1:0] data_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_r;
    logic [n-1:0]   buf1_r;
    logic [1:0]     occ_r;
    logic           inflight_r;
    logic [a:0]     remain_r;

    logic           pop_s;
    logic           issue_s;
    logic           last_pop_s;
    logic [n-1:0]   buf0_s;
    logic [n-1:0]   buf1_s;
    logic [1:0]     occ_s;
    logic [2:0]     pending_s;

    // Issue decision: occupancy after this edge's pop plus the word already in flight must leave room.
    always_comb begin
        pop_s      = valid_o & ready_i;
        pending_s  = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s    = (state_r == RUN) && (pending_s < 3'd2);
        last_pop_s = (state_r == DRAIN) && pop_s && (occ_r == 2'd1) && !inflight_r;
    end

    // Next buffer contents: data_o is the head, buf1_r the tail; capture and pop may coincide.
    always_comb begin
        buf0_s = data_o;
        buf1_s = buf1_r;
        occ_s  = occ_r;
        case ({inflight_r, pop_s})
            2'b10: begin
                if (occ_r == 2'd0) begin
                    buf0_s = rom_d;
                end else begin
                    buf1_s = rom_d;
                end
                occ_s = occ_r + 2'd1;
            end
            2'b01: begin
                buf0_s = buf1_r;
                occ_s  = occ_r - 2'd1;
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    buf0_s = rom_d;
                end else begin
                    buf0_s = buf1_r;
                    buf1_s = rom_d;
                end
            end
            default: begin
                occ_s = occ_r;
            end
        endcase
    end

    // Control FSM with registered stream, address and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_o     <= {a{1'b0}};
            data_o     <= {n{1'b0}};
            buf1_r     <= {n{1'b0}};
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            remain_r   <= {(a+1){1'b0}};
            valid_o    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        if (len == {(a+1){1'b0}}) begin
                            done <= 1'b1;
                        end else begin
                            state_r  <= RUN;
                            addr_o   <= base;
                            remain_r <= len;
                            busy     <= 1'b1;
                        end
                    end
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        state_r    <= IDLE;
                        data_o     <= {n{1'b0}};
                        buf1_r     <= {n{1'b0}};
                        occ_r      <= 2'd0;
                        inflight_r <= 1'b0;
                        valid_o    <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        data_o     <= buf0_s;
                        buf1_r     <= buf1_s;
                        occ_r      <= occ_s;
                        valid_o    <= (occ_s != 2'd0);
                        inflight_r <= issue_s;
                        if (issue_s) begin
                            // Non-power-of-two depths still wrap at m-1.
                            addr_o   <= (addr_o == a'(m - 1)) ? {a{1'b0}} : addr_o + a'(1);
                            remain_r <= remain_r - (a+1)'(1);
                            if (remain_r == (a+1)'(1)) begin
                                state_r <= DRAIN;
                            end
                        end
                        if (last_pop_s) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
